pipe_stage_reg: RTL



---
 rtl/pipe_pkg.sv | 83 ++++++++
 rtl/pipe_slot.sv | 42 ++++
 rtl/pipe_stage_reg.sv | 108 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared widths, field layouts and control bit positions for the MIPS stage registers.
// No logic; types and constants only.
// Imported by pipe_slot and pipe_stage_reg.
package pipe_pkg;

  // IF/ID: fetched instruction and its link address
  localparam int IFID_CTRL_W   = 1;
  localparam int IFID_DATA_W   = 64;
  // ID/EXE: decoded controls, operands and destination candidates
  localparam int IDEXE_CTRL_W  = 8;
  localparam int IDEXE_DATA_W  = 106;
  // EXE/MEM: ALU result, store data and destination register
  localparam int EXEMEM_CTRL_W = 4;
  localparam int EXEMEM_DATA_W = 69;
  // MEM/WB: load data, ALU result and destination register
  localparam int MEMWB_CTRL_W  = 2;
  localparam int MEMWB_DATA_W  = 69;

  typedef struct packed {
    logic in_delay_slot;
  } ifid_ctrl_t;

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } ifid_data_t;

  typedef struct packed {
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } idexe_ctrl_t;

  typedef struct packed {
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } idexe_data_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
    logic mem_write;
    logic mem_read;
  } exemem_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] rt_val;
    logic [4:0]  reg_dest;
  } exemem_data_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } memwb_ctrl_t;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic [31:0] alu_res;
    logic [4:0]  reg_dest;
  } memwb_data_t;

  // Control bit positions inside the packed control words
  localparam int EXEMEM_MEM_READ_BIT   = 0;
  localparam int EXEMEM_MEM_WRITE_BIT  = 1;
  localparam int EXEMEM_REG_WRITE_BIT  = 2;
  localparam int EXEMEM_MEM_TO_REG_BIT = 3;
  localparam int MEMWB_REG_WRITE_BIT   = 0;
  localparam int MEMWB_MEM_TO_REG_BIT  = 1;

  // Number of held entries from the two slot valid flags
  function automatic logic [1:0] occ_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One valid-tagged storage entry (control + data) of a stage register.
// Latency: loaded value visible after the next rising edge.
// No flow control of its own; the owner decides load/clear each cycle.
// Ports: clk, rst_n (sync, active-low), flush, load, clear, ld_ctrl/ld_data in;
//        valid, ctrl, data out.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = EXEMEM_CTRL_W,
  parameter int DATA_W = EXEMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Flush beats load so a beat accepted during a squash is dropped;
  // payload registers are left alone on flush/clear (output gating hides ctrl).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= ld_ctrl;
      data  <= ld_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready inter-stage pipeline register with flush, bubble gating and stall counter.
// Latency 1 cycle; throughput 1 beat/cycle in both SKID modes.
// SKID=1: registered in_ready via a second entry; SKID=0: in_ready = !out_valid | out_ready.
// Ports: clk, rst_n, flush; in_valid/in_ready/in_ctrl/in_data upstream;
//        out_valid/out_ready/out_ctrl/out_data downstream; occupancy, stall_cnt status.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = EXEMEM_CTRL_W,
  parameter int DATA_W = EXEMEM_DATA_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              m_vld;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic              s_vld;
  logic              acc;
  logic              dlv;

  assign acc = in_valid & in_ready;
  assign dlv = m_vld & out_ready;

  if (SKID != 0) begin : g_skid
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;
    logic              m_free;  // main entry is empty or leaving this cycle

    assign m_free   = ~m_vld | out_ready;
    // s_vld is a flop, so no path from out_ready to in_ready
    assign in_ready = ~s_vld;

    // Main refills from skid first (older beat), else from the input
    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .load    (m_free & (s_vld | acc)),
      .clear   (dlv),
      .ld_ctrl (s_vld ? s_ctrl : in_ctrl),
      .ld_data (s_vld ? s_data : in_data),
      .valid   (m_vld),
      .ctrl    (m_ctrl),
      .data    (m_data)
    );

    // Skid catches a beat only when main is occupied and stuck
    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .load    (acc & ~m_free),
      .clear   (m_free),
      .ld_ctrl (in_ctrl),
      .ld_data (in_data),
      .valid   (s_vld),
      .ctrl    (s_ctrl),
      .data    (s_data)
    );
  end else begin : g_single
    assign s_vld    = 1'b0;
    assign in_ready = ~m_vld | out_ready;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .load    (acc),
      .clear   (dlv),
      .ld_ctrl (in_ctrl),
      .ld_data (in_data),
      .valid   (m_vld),
      .ctrl    (m_ctrl),
      .data    (m_data)
    );
  end

  assign out_valid = m_vld;
  // Bubbles carry all-zero control so downstream write enables stay off
  assign out_ctrl  = m_vld ? m_ctrl : '0;
  assign out_data  = m_data;
  assign occupancy = occ_count(m_vld, s_vld);

  // Saturating stall counter; only reset clears it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
